// File: rtl/interrupt_acknowledge_sequencer.sv
// INTA# handshake sequencer for the 8259A control logic: resolves the winning request,
// owns the in-service register and drives the vector bytes onto the internal bus.
module interrupt_acknowledge_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       interrupt_acknowledge_n,
    input  logic       write_initial_command_word_1,
    input  logic       mode_8086,
    input  logic [4:0] interrupt_vector_base,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] interrupt_mask,
    input  logic [2:0] priority_rotate,
    input  logic [7:0] end_of_interrupt,
    output logic       interrupt_to_cpu,
    output logic [7:0] in_service_register,
    output logic [7:0] highest_level_in_service,
    output logic [7:0] acknowledge_interrupt,
    output logic       end_of_acknowledge_sequence,
    output logic       out_control_logic_data,
    output logic [7:0] control_logic_data
);

    typedef enum logic [1:0] {IDLE, ACK1, ACK2, ACK3} state_t;

    state_t     state, state_next;
    logic       prev_inta;
    logic       mode_latched, mode_next;
    logic [2:0] level, level_next;
    logic       fall, rise, seq_end;
    logic [7:0] set_mask, resolved;
    logic [3:0] res_find, isr_find;
    logic [2:0] res_level, isr_level;
    logic       outranks;
    logic       drive_en_next;
    logic [7:0] drive_data_next;

    // Returns {valid, rank}; rank 0 is the highest-priority level (priority_rotate + 1).
    function automatic logic [3:0] find_rank(input logic [7:0] v, input logic [2:0] rot);
        logic [15:0] dbl;
        logic [3:0]  r;
        dbl = {v, v} >> ({1'b0, rot} + 4'd1);
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (dbl[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    assign fall = prev_inta & ~interrupt_acknowledge_n;
    assign rise = ~prev_inta & interrupt_acknowledge_n;

    always_comb begin
        res_find  = find_rank(interrupt_request_register & ~interrupt_mask, priority_rotate);
        isr_find  = find_rank(in_service_register, priority_rotate);
        res_level = res_find[2:0] + priority_rotate + 3'd1;
        isr_level = isr_find[2:0] + priority_rotate + 3'd1;
        resolved  = res_find[3] ? (8'b1 << res_level) : 8'h00;
        highest_level_in_service = isr_find[3] ? (8'b1 << isr_level) : 8'h00;
        outranks  = res_find[3] && (!isr_find[3] || (res_find[2:0] < isr_find[2:0]));
    end

    always_comb begin
        state_next = state;
        level_next = level;
        mode_next  = mode_latched;
        set_mask   = 8'h00;
        seq_end    = 1'b0;
        case (state)
            IDLE: if (fall) begin
                state_next = ACK1;
                level_next = res_find[3] ? res_level : 3'd7;   // spurious uses level 7
                mode_next  = mode_8086;
                set_mask   = resolved;
            end
            ACK1: if (fall) state_next = ACK2;
            ACK2: begin
                if (fall && !mode_latched) begin
                    state_next = ACK3;
                end else if (rise && mode_latched) begin
                    state_next = IDLE;
                    seq_end    = 1'b1;
                end
            end
            ACK3: if (rise) begin
                state_next = IDLE;
                seq_end    = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        drive_en_next   = 1'b0;
        drive_data_next = 8'h00;
        if (!interrupt_acknowledge_n) begin
            case (state_next)
                ACK1: if (!mode_next) begin
                    drive_en_next   = 1'b1;
                    drive_data_next = 8'hCD;
                end
                ACK2: begin
                    drive_en_next   = 1'b1;
                    drive_data_next = mode_next ? {interrupt_vector_base, level_next}
                                                : {interrupt_vector_base[2:0], level_next, 2'b00};
                end
                ACK3: begin
                    drive_en_next   = 1'b1;
                    drive_data_next = {3'b000, interrupt_vector_base};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                       <= IDLE;
            prev_inta                   <= 1'b1;
            mode_latched                <= 1'b0;
            level                       <= 3'd0;
            interrupt_to_cpu            <= 1'b0;
            in_service_register         <= 8'h00;
            acknowledge_interrupt       <= 8'h00;
            end_of_acknowledge_sequence <= 1'b0;
            out_control_logic_data      <= 1'b0;
            control_logic_data          <= 8'h00;
        end else if (write_initial_command_word_1) begin
            state                       <= IDLE;
            prev_inta                   <= 1'b1;
            mode_latched                <= 1'b0;
            level                       <= 3'd0;
            interrupt_to_cpu            <= 1'b0;
            in_service_register         <= 8'h00;
            acknowledge_interrupt       <= 8'h00;
            end_of_acknowledge_sequence <= 1'b0;
            out_control_logic_data      <= 1'b0;
            control_logic_data          <= 8'h00;
        end else begin
            state                       <= state_next;
            prev_inta                   <= interrupt_acknowledge_n;
            mode_latched                <= mode_next;
            level                       <= level_next;
            in_service_register         <= (in_service_register & ~end_of_interrupt) | set_mask;
            end_of_acknowledge_sequence <= seq_end;
            out_control_logic_data      <= drive_en_next;
            control_logic_data          <= drive_data_next;
            if (end_of_acknowledge_sequence) acknowledge_interrupt <= 8'h00;
            if (state == IDLE && fall)       acknowledge_interrupt <= resolved;
            if (fall)                        interrupt_to_cpu <= 1'b0;
            else if (state == IDLE)          interrupt_to_cpu <= outranks;
        end
    end

endmodule

// File: tb/tb_interrupt_acknowledge_sequencer.sv
// Bench for interrupt_acknowledge_sequencer: directed scenarios followed by random
// acknowledge sequences checked against a transaction-level model.
module tb_interrupt_acknowledge_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       interrupt_acknowledge_n;
    logic       write_initial_command_word_1;
    logic       mode_8086;
    logic [4:0] interrupt_vector_base;
    logic [7:0] interrupt_request_register;
    logic [7:0] interrupt_mask;
    logic [2:0] priority_rotate;
    logic [7:0] end_of_interrupt;
    logic       interrupt_to_cpu;
    logic [7:0] in_service_register;
    logic [7:0] highest_level_in_service;
    logic [7:0] acknowledge_interrupt;
    logic       end_of_acknowledge_sequence;
    logic       out_control_logic_data;
    logic [7:0] control_logic_data;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] isr_m = 8'h00;

    interrupt_acknowledge_sequencer dut (
        .clock                        (clock),
        .reset                        (reset),
        .interrupt_acknowledge_n      (interrupt_acknowledge_n),
        .write_initial_command_word_1 (write_initial_command_word_1),
        .mode_8086                    (mode_8086),
        .interrupt_vector_base        (interrupt_vector_base),
        .interrupt_request_register   (interrupt_request_register),
        .interrupt_mask               (interrupt_mask),
        .priority_rotate              (priority_rotate),
        .end_of_interrupt             (end_of_interrupt),
        .interrupt_to_cpu             (interrupt_to_cpu),
        .in_service_register          (in_service_register),
        .highest_level_in_service     (highest_level_in_service),
        .acknowledge_interrupt        (acknowledge_interrupt),
        .end_of_acknowledge_sequence  (end_of_acknowledge_sequence),
        .out_control_logic_data       (out_control_logic_data),
        .control_logic_data           (control_logic_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Highest-priority set level of v under rotation r, or -1 when v is empty.
    function automatic int top_level(input logic [7:0] v, input logic [2:0] r);
        int l;
        for (int i = 1; i <= 8; i++) begin
            l = (int'(r) + i) % 8;
            if (v[l]) return l;
        end
        return -1;
    endfunction

    function automatic int rank_of(input int l, input logic [2:0] r);
        return (l + 7 - int'(r)) % 8;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_int"},  {7'b0, interrupt_to_cpu}, 8'h00);
        chk({tag, "_isr"},  in_service_register, 8'h00);
        chk({tag, "_hlis"}, highest_level_in_service, 8'h00);
        chk({tag, "_ack"},  acknowledge_interrupt, 8'h00);
        chk({tag, "_eoa"},  {7'b0, end_of_acknowledge_sequence}, 8'h00);
        chk({tag, "_en"},   {7'b0, out_control_logic_data}, 8'h00);
        chk({tag, "_data"}, control_logic_data, 8'h00);
    endtask

    task automatic eoi_cycle(input logic [7:0] m);
        end_of_interrupt = m;
        step();
        end_of_interrupt = 8'h00;
        isr_m = isr_m & ~m;
        chk("eoi_isr", in_service_register, isr_m);
    endtask

    task automatic pulse(input int n, input int total, input logic [7:0] exp_ack,
                         input bit drive, input logic [7:0] exp_byte,
                         input logic [7:0] eoi_here, input logic [7:0] set_m, input int hold);
        interrupt_acknowledge_n = 1'b0;
        end_of_interrupt = eoi_here;
        step();
        end_of_interrupt = 8'h00;
        if (n == 1) isr_m = (isr_m & ~eoi_here) | set_m;
        chk("fall_ack", acknowledge_interrupt, exp_ack);
        chk("fall_isr", in_service_register, isr_m);
        chk("fall_int", {7'b0, interrupt_to_cpu}, 8'h00);
        chk("fall_en",  {7'b0, out_control_logic_data}, {7'b0, drive});
        if (drive) chk("fall_data", control_logic_data, exp_byte);
        chk("fall_eoa", {7'b0, end_of_acknowledge_sequence}, 8'h00);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_en", {7'b0, out_control_logic_data}, {7'b0, drive});
        end
        interrupt_acknowledge_n = 1'b1;
        step();
        chk("rise_en", {7'b0, out_control_logic_data}, 8'h00);
        if (n == total) begin
            chk("rise_eoa", {7'b0, end_of_acknowledge_sequence}, 8'h01);
            chk("rise_ack", acknowledge_interrupt, exp_ack);
            step();
            chk("post_eoa", {7'b0, end_of_acknowledge_sequence}, 8'h00);
            chk("post_ack", acknowledge_interrupt, 8'h00);
            chk("post_isr", in_service_register, isr_m);
        end else begin
            chk("mid_eoa", {7'b0, end_of_acknowledge_sequence}, 8'h00);
            chk("mid_ack", acknowledge_interrupt, exp_ack);
        end
    endtask

    task automatic run_txn(input logic [2:0] rot, input logic [7:0] irr, input logic [7:0] imr,
                           input logic [4:0] base, input bit mode, input logic [7:0] eoi,
                           input bit perturb, input int hold);
        int         res, hl, total;
        bit         exp_int;
        logic [2:0] lvl;
        logic [7:0] set_m;
        logic [7:0] bytes [3];
        bit         drv [3];
        priority_rotate = rot;
        interrupt_request_register = irr;
        interrupt_mask = imr;
        interrupt_vector_base = base;
        mode_8086 = mode;
        step();
        step();
        res = top_level(irr & ~imr, rot);
        hl  = top_level(isr_m, rot);
        exp_int = (res >= 0) && ((hl < 0) || (rank_of(res, rot) < rank_of(hl, rot)));
        chk("idle_int",  {7'b0, interrupt_to_cpu}, {7'b0, exp_int});
        chk("idle_hlis", highest_level_in_service, (hl < 0) ? 8'h00 : (8'h01 << hl));
        lvl   = (res < 0) ? 3'd7 : 3'(res);
        set_m = (res < 0) ? 8'h00 : (8'h01 << res);
        if (mode) begin
            total = 2;
            drv[0] = 1'b0; bytes[0] = 8'h00;
            drv[1] = 1'b1; bytes[1] = {base, lvl};
            drv[2] = 1'b0; bytes[2] = 8'h00;
        end else begin
            total = 3;
            drv[0] = 1'b1; bytes[0] = 8'hCD;
            drv[1] = 1'b1; bytes[1] = {base[2:0], lvl, 2'b00};
            drv[2] = 1'b1; bytes[2] = {3'b000, base};
        end
        for (int p = 1; p <= total; p++) begin
            pulse(p, total, set_m, drv[p-1], bytes[p-1], (p == 1) ? eoi : 8'h00, set_m, hold);
            if (perturb && p == 1) begin
                mode_8086 = ~mode;
                interrupt_request_register = 8'($urandom);
                interrupt_mask = 8'($urandom);
            end
        end
        mode_8086 = mode;
    endtask

    initial begin
        reset = 1'b1;
        interrupt_acknowledge_n = 1'b1;
        write_initial_command_word_1 = 1'b0;
        mode_8086 = 1'b1;
        interrupt_vector_base = 5'd0;
        interrupt_request_register = 8'h00;
        interrupt_mask = 8'h00;
        priority_rotate = 3'd7;
        end_of_interrupt = 8'h00;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // Basic 8086 flow: level 2, vector 8'h42
        run_txn(3'd7, 8'h24, 8'h00, 5'b01000, 1'b1, 8'h00, 1'b0, 0);
        eoi_cycle(8'h04);
        // Rotated priority: level 3 beats level 0
        run_txn(3'd2, 8'h09, 8'h00, 5'b01000, 1'b1, 8'h00, 1'b0, 1);
        eoi_cycle(8'h08);
        // 8080 three-pulse: CD, BC, 15
        run_txn(3'd7, 8'h80, 8'h00, 5'b10101, 1'b0, 8'h00, 1'b0, 0);
        eoi_cycle(8'h80);
        // Spurious acknowledge
        run_txn(3'd7, 8'h00, 8'h00, 5'b11001, 1'b1, 8'h00, 1'b0, 0);
        // Simultaneous set and clear of level 2
        run_txn(3'd7, 8'h04, 8'h00, 5'b00110, 1'b1, 8'h00, 1'b0, 0);
        run_txn(3'd7, 8'h04, 8'h00, 5'b00110, 1'b1, 8'h04, 1'b0, 0);
        chk("simul_isr", in_service_register, 8'h04);
        eoi_cycle(8'h04);

        // Async reset while in ACK1
        interrupt_request_register = 8'h01;
        interrupt_acknowledge_n = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        interrupt_acknowledge_n = 1'b1;
        step();
        reset = 1'b0;
        step();
        isr_m = 8'h00;
        run_txn(3'd7, 8'h01, 8'h00, 5'b00011, 1'b1, 8'h00, 1'b0, 0);
        eoi_cycle(8'h01);

        // ICW1 re-init while in ACK1
        interrupt_request_register = 8'h10;
        interrupt_acknowledge_n = 1'b0;
        step();
        chk("icw1_pre_isr", in_service_register, 8'h10);
        write_initial_command_word_1 = 1'b1;
        interrupt_acknowledge_n = 1'b1;
        step();
        write_initial_command_word_1 = 1'b0;
        check_all_zero("icw1");
        isr_m = 8'h00;
        run_txn(3'd7, 8'h10, 8'h00, 5'b00111, 1'b0, 8'h00, 1'b0, 0);
        eoi_cycle(8'h10);

        // Random sequences
        for (int t = 0; t < 40; t++) begin
            int hl;
            run_txn(3'($urandom), 8'($urandom), 8'($urandom_range(0, 1) ? $urandom : 0),
                    5'($urandom), 1'($urandom), 8'h00, 1'($urandom), int'($urandom_range(0, 2)));
            hl = top_level(isr_m, priority_rotate);
            if (hl >= 0 && $urandom_range(0, 1) == 1) eoi_cycle(8'h01 << hl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
